// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the pipelined-write register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned ZERO_REG_IDX   = 0;

  function automatic int unsigned num_regs(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/regfile_pipelined_wr_decoder.sv
// Parametrised log2(N)-to-N one-hot decoder with enable.
module decoder_n_to_onehot
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]    in,
  input  logic                     en,
  output logic [2**ADDR_WIDTH-1:0] out
);

  localparam int unsigned NUM_OUT = num_regs(ADDR_WIDTH);

  // One comparator per output line; at most one line can match.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_dec
    assign out[i] = en && (in == ADDR_WIDTH'(i));
  end

endmodule

// File: rtl/regfile_pipelined_wr.sv
// Register file with two combinational read ports and one write port that
// is captured into a one-entry pending stage and committed an edge later.
module regfile_pipelined_wr
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                     clock,
  input  logic                     ctrl_reset_n,
  input  logic                     ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]    ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]    data_writeReg,
  input  logic [ADDR_WIDTH-1:0]    ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0]    ctrl_readRegB,
  output logic [DATA_WIDTH-1:0]    data_readRegA,
  output logic [DATA_WIDTH-1:0]    data_readRegB,
  output logic                     wr_pending,
  output logic [2**ADDR_WIDTH-1:0] reg_written
);

  localparam int unsigned NUM_REGS = num_regs(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG_IDX);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_data;
  logic [NUM_REGS-1:0]   commit_en;
  logic                  accept;

  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];

  // Writes to the hard-wired zero register never enter the pipeline.
  always_comb begin
    accept = ctrl_writeEnable && !(ZERO_REG && (ctrl_writeReg == ZERO_ADDR));
  end

  decoder_n_to_onehot #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_commit_dec (
    .in (pend_addr),
    .en (pend_valid),
    .out(commit_en)
  );

  // Stage 1: capture the incoming write into the pending entry.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= accept;
      if (accept) begin
        pend_addr <= ctrl_writeReg;
        pend_data <= data_writeReg;
      end
    end
  end

  // Stage 2: commit the pending entry into the array and mark it written.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_written <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (commit_en[i]) regs[i] <= pend_data;
      end
      reg_written <= reg_written | commit_en;
    end
  end

  // Per-port read mux: zero register, then pending forward, then array.
  always_comb begin
    rd_addr[0] = ctrl_readRegA;
    rd_addr[1] = ctrl_readRegB;
    for (int unsigned p = 0; p < 2; p++) begin
      if (ZERO_REG && (rd_addr[p] == ZERO_ADDR)) begin
        rd_data[p] = '0;
      end else if (BYPASS && pend_valid && (pend_addr == rd_addr[p])) begin
        rd_data[p] = pend_data;
      end else begin
        rd_data[p] = regs[rd_addr[p]];
      end
    end
  end

  assign data_readRegA = rd_data[0];
  assign data_readRegB = rd_data[1];
  assign wr_pending    = pend_valid;

endmodule
